// File: rtl/gate_selftest_seq.sv
// Built-in self-test sequencer for the shared-input AND/OR/NOT gate datapath.
// Walks {a,b} through 00,01,10,11, lets each vector settle, then grades every gate output.
module gate_selftest_seq #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_not,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_gate,
    output logic [1:0] vec_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Counter value on the last settle cycle of a vector.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] vec_q, vec_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] gate_q, gate_d;
    logic       pass_q, pass_d;
    logic [2:0] gate_fail;

    // Grade against the registered drive values, which are what the gates actually see.
    always_comb begin
        gate_fail[0] = (y_and != (a_q & b_q));
        gate_fail[1] = (y_or  != (a_q | b_q));
        gate_fail[2] = (y_not != ~a_q);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        mask_d  = mask_q;
        gate_d  = gate_q;
        pass_d  = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    hold_d  = 4'd0;
                    mask_d  = 4'd0;
                    gate_d  = 3'd0;
                    pass_d  = 1'b0;
                end
            end

            S_DRIVE: begin
                a_d    = vec_q[1];
                b_d    = vec_q[0];
                hold_d = hold_q + 4'd1;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                if (|gate_fail) begin
                    mask_d[vec_q] = 1'b1;
                    gate_d        = gate_q | gate_fail;
                end
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                    // Includes any failure captured on this final vector.
                    pass_d  = (mask_d == 4'd0);
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_q + 2'd1;
                    hold_d  = 4'd0;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= 4'd0;
            vec_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mask_q  <= 4'd0;
            gate_q  <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            gate_q  <= gate_d;
            pass_q  <= pass_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign err_mask = mask_q;
    assign err_gate = gate_q;
    assign vec_idx  = vec_q;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: behavioural gates with injectable faults, per-cycle
// expected outputs queued at stimulus time and compared at each falling edge.
module tb_gate_selftest_seq;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       a;
        logic       b;
        logic [1:0] vec;
        logic       pass;
        logic [3:0] mask;
        logic [2:0] gate;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0;
    logic start1 = 1'b0;
    logic f_and = 1'b0;
    logic f_not = 1'b0;
    logic sel = 1'b0;

    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] mask2;
    logic [2:0] gate2;
    logic [1:0] vec2;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [2:0] gate1;
    logic [1:0] vec1;

    logic y_and2, y_or2, y_not2, y_and1, y_or1, y_not1;

    assign y_and2 = f_and ? 1'b1 : (a2 & b2);
    assign y_or2  = a2 | b2;
    assign y_not2 = f_not ? a2 : ~a2;
    assign y_and1 = f_and ? 1'b1 : (a1 & b1);
    assign y_or1  = a1 | b1;
    assign y_not1 = f_not ? a1 : ~a1;

    gate_selftest_seq #(.HOLD_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .y_and(y_and2), .y_or(y_or2), .y_not(y_not2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_mask(mask2), .err_gate(gate2), .vec_idx(vec2)
    );

    gate_selftest_seq #(.HOLD_CYCLES(1)) u_dut_h1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .y_and(y_and1), .y_or(y_or1), .y_not(y_not1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(mask1), .err_gate(gate1), .vec_idx(vec1)
    );

    always #5 clk = ~clk;

    obs_t  obs2, obs1;
    assign obs2 = '{busy: busy2, done: done2, a: a2, b: b2, vec: vec2,
                    pass: pass2, mask: mask2, gate: gate2};
    assign obs1 = '{busy: busy1, done: done1, a: a1, b: b1, vec: vec1,
                    pass: pass1, mask: mask1, gate: gate1};

    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string tag = "init";

    function automatic obs_t mk_idle(logic [1:0] vec, logic p, logic [3:0] m, logic [2:0] g);
        obs_t e;
        e = '0;
        e.vec  = vec;
        e.pass = p;
        e.mask = m;
        e.gate = g;
        return e;
    endfunction

    task automatic push_idle(int n, obs_t e);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expected per-cycle outputs for a whole run; flags from the truth-table model,
    // done-cycle values from the caller's constants.
    task automatic push_run(int hold, logic fa, logic fn,
                            logic [3:0] fin_mask, logic [2:0] fin_gate, logic fin_pass);
        obs_t       e;
        logic [3:0] m;
        logic [2:0] g;
        logic [1:0] kv;
        logic       av, bv;
        logic [2:0] bad;
        m = 4'd0;
        g = 3'd0;
        for (int k = 0; k < 4; k++) begin
            kv = 2'(k);
            av = kv[1];
            bv = kv[0];
            for (int h = 0; h <= hold; h++) begin
                e = '{busy: 1'b1, done: 1'b0, a: av, b: bv, vec: kv,
                      pass: 1'b0, mask: m, gate: g};
                exp_q.push_back(e);
            end
            bad[0] = ((fa ? 1'b1 : (av & bv)) != (av & bv));
            bad[1] = 1'b0;
            bad[2] = ((fn ? av : ~av) != ~av);
            if (|bad) begin
                m[k] = 1'b1;
                g    = g | bad;
            end
        end
        e = '{busy: 1'b0, done: 1'b1, a: 1'b0, b: 1'b0, vec: 2'd3,
              pass: fin_pass, mask: fin_mask, gate: fin_gate};
        exp_q.push_back(e);
    endtask

    task automatic cycle_check();
        obs_t o;
        obs_t e;
        @(negedge clk);
        cyc++;
        o = sel ? obs1 : obs2;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s cyc=%0d scoreboard empty, got %b", tag, cyc, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e)
            else begin
                errors++;
                $error("FAIL %s cyc=%0d got busy,done,a,b,vec,pass,mask,gate=%b want %b",
                       tag, cyc, o, e);
            end
        end
    endtask

    task automatic set_start(logic v);
        if (sel) start1 = v;
        else     start2 = v;
    endtask

    // Called just after a falling edge with the selected DUT idle or in DONE.
    task automatic run(int hold, logic fa, logic fn, logic [3:0] fm, logic [2:0] fg,
                       logic fp, bit hold_start, bit restart);
        int n;
        f_and = fa;
        f_not = fn;
        set_start(1'b1);
        push_run(hold, fa, fn, fm, fg, fp);
        n = 4 * (hold + 1) + 1;
        for (int i = 0; i < n; i++) begin
            cycle_check();
            if (i == n - 1) set_start(restart ? 1'b1 : 1'b0);
            else if (!hold_start) set_start(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        tag = "reset_h2";
        sel = 1'b0;
        push_idle(1, '0);
        cycle_check();
        tag = "reset_h1";
        sel = 1'b1;
        push_idle(1, '0);
        cycle_check();
        sel = 1'b0;
        rst = 1'b0;

        tag = "golden_h2";
        run(2, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0);
        push_idle(2, mk_idle(2'd3, 1'b1, 4'b0000, 3'b000));
        cycle_check();
        cycle_check();

        tag = "and_stuck1";
        run(2, 1'b1, 1'b0, 4'b0111, 3'b001, 1'b0, 1'b0, 1'b0);
        push_idle(1, mk_idle(2'd3, 1'b0, 4'b0111, 3'b001));
        cycle_check();

        tag = "not_buffer";
        run(2, 1'b0, 1'b1, 4'b1111, 3'b100, 1'b0, 1'b0, 1'b1);
        tag = "restart_golden";
        run(2, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0);
        push_idle(1, mk_idle(2'd3, 1'b1, 4'b0000, 3'b000));
        cycle_check();

        tag = "start_held";
        run(2, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b1, 1'b0);
        push_idle(3, mk_idle(2'd3, 1'b1, 4'b0000, 3'b000));
        repeat (3) cycle_check();

        tag = "rst_midrun";
        set_start(1'b1);
        push_run(2, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle_check();
            set_start(1'b0);
        end
        rst = 1'b1;
        exp_q.delete();
        push_idle(1, '0);
        cycle_check();
        rst = 1'b0;
        tag = "post_rst_idle";
        push_idle(3, '0);
        repeat (3) cycle_check();
        tag = "post_rst_run";
        run(2, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0);
        push_idle(1, mk_idle(2'd3, 1'b1, 4'b0000, 3'b000));
        cycle_check();

        tag = "golden_h1";
        sel = 1'b1;
        run(1, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0);
        push_idle(2, mk_idle(2'd3, 1'b1, 4'b0000, 3'b000));
        repeat (2) cycle_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_selftest_seq.md
# gate_selftest_seq

Sequencer that exhaustively exercises the basic-gate datapath (AND, OR and NOT gate instances sharing inputs `a`, `b`) in silicon or simulation without a hand-written stimulus block. On a `start` pulse it steps the shared inputs through all four combinations, waits a programmable settle time per vector, and checks each gate output against its expected truth table. It reports per-vector and per-gate error masks plus a pass flag. It sits directly above the gate instances and is their only driver.

## Interface

- Reset is synchronous and active-high; one clock (`clk`), reset port `rst`.

Parameters:

- `HOLD_CYCLES`, default 2, settle cycles per vector before sampling; legal range 1..15.

Ports:

- `clk` input, 1 bit, rising-edge clock.
- `rst` input, 1 bit, synchronous active-high reset.
- `start` input, 1 bit, begin a run. Sampled only in IDLE or DONE.
- `a` output, 1 bit, shared gate input A. Registered.
- `b` output, 1 bit, shared gate input B. Registered.
- `y_and` input, 1 bit, AND gate output.
- `y_or` input, 1 bit, OR gate output.
- `y_not` input, 1 bit, NOT gate output (of `a`).
- `busy` output, 1 bit, run in progress.
- `done` output, 1 bit, one-cycle pulse at end of run.
- `pass` output, 1 bit, last run had zero mismatches.
- `err_mask` output, 4 bits, bit k set if any gate failed on vector k.
- `err_gate` output, 3 bits, sticky per-gate fail flags: bit0 AND, bit1 OR, bit2 NOT.
- `vec_idx` output, 2 bits, current vector index; `{a,b}` = `vec_idx`.

## Operation

- **States:** IDLE, DRIVE, SAMPLE, DONE.
- **IDLE:**
  - `start`=1 → DRIVE.
  - On that same edge: `vec_idx`=0, `err_mask`=0, `err_gate`=0, `pass`=0, hold counter=0.
- **DRIVE:**
  - `a`=`vec_idx[1]`, `b`=`vec_idx[0]`.
  - Hold counter increments each cycle.
  - After `HOLD_CYCLES` cycles in DRIVE → SAMPLE.
- **SAMPLE (one cycle):**
  - `a`/`b` unchanged.
  - Compare inputs against expected values:
    - `y_and` vs `a&b`
    - `y_or` vs `a|b`
    - `y_not` vs `~a`
  - On any mismatch: set `err_mask[vec_idx]` and OR the mismatching gate bits into `err_gate` (registered at the end of the SAMPLE cycle).
  - If `vec_idx`==3 → DONE; else `vec_idx`+1, hold counter=0 → DRIVE.
- **DONE (one cycle):**
  - `done`=1.
  - `pass`=1 iff the final `err_mask`==0, including any error captured on vector 3.
  - `start`=1 in DONE behaves as in IDLE (restart) and goes to DRIVE; otherwise → IDLE.
- **Outside DRIVE/SAMPLE:** `a`=`b`=0, `vec_idx` holds its last value. `pass`, `err_mask` and `err_gate` hold until the next accepted `start`.
- **While busy:** `start` is ignored.
- **Output decodes:** `busy`=1 in DRIVE and SAMPLE only; `done`=1 in DONE only.
- **Input handling:** `y_*` are treated as settled combinational values. There is no input synchronizer.

## Timing

- **Reset:** `rst`=1 at a rising edge forces IDLE, with `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `err_gate`=0, `vec_idx`=0. It takes priority over `start` and over any mid-run state; the aborted run produces no `done`.
- **Start to drive:** with `start` sampled high at edge N, `busy`=1 and vector 0 is on `a`/`b` from N+1.
- **Per-vector cost:** `HOLD_CYCLES`+1 cycles.
- **Sampling point:** vector k is sampled in cycle N+1+k·(`HOLD_CYCLES`+1)+`HOLD_CYCLES`.
- **Run end:** `done` is high in cycle N+1+4·(`HOLD_CYCLES`+1).
  - Default `HOLD_CYCLES`=2: cycle N+13.
- **End-of-run flags:** `pass`/`err_mask`/`err_gate` are final and valid in the `done` cycle.
- **Vector timing:** `a`/`b` change only on the SAMPLE→DRIVE edge and on DRIVE entry/exit.

## Test plan

- **Golden gates, `HOLD_CYCLES`=2:** start at N → `a`/`b` sequence 00,01,10,11 with each vector held 3 cycles; `done` at N+13; `pass`=1, `err_mask`=0000, `err_gate`=000.
- **AND output stuck at 1:** → `err_mask`=0111, `err_gate`=001, `pass`=0.
- **NOT replaced by a buffer (`y_not`=`a`):** → `err_mask`=1111, `err_gate`=100, `pass`=0. Then run a golden start-restart in the DONE cycle → flags cleared and the next `done` gives `pass`=1.
- **`start` re-asserted every cycle during a run:** → no restart, `done` exactly once at N+13, `vec_idx` sequence unaffected.
- **`rst` asserted at N+6 (mid vector 1):** → next cycle IDLE with all outputs zero; no `done`. A following start runs a full, clean 13-cycle sequence.
- **`HOLD_CYCLES`=1, golden gates:** → each vector held 2 cycles, `done` at N+9, `pass`=1.
